// File: rtl/pwm_pkg.sv
// pwm_pkg: sweep FSM states and default PWM resolution shared by servo_pwm and servo_sweep_ctrl
package pwm_pkg;
    localparam int PWM_RES = 8;
    typedef enum logic [2:0] {IDLE, RISE, DWELL_HI, FALL, DWELL_LO} sweep_state_t;
endpackage

// File: rtl/servo_sweep_ctrl_if.sv
// servo_sweep_ctrl_if: sweep command/limit inputs and duty/status outputs of the sweep sequencer
interface servo_sweep_ctrl_if import pwm_pkg::*; #(parameter int R = PWM_RES);
    logic start;
    logic stop;
    logic [R:0] min_duty;
    logic [R:0] max_duty;
    logic [R-1:0] step;
    logic [7:0] n_cycles;
    logic [R:0] duty;
    logic active;
    logic done;
    logic err;
    modport master(output start, stop, min_duty, max_duty, step, n_cycles, input duty, active, done, err);
    modport slave(input start, stop, min_duty, max_duty, step, n_cycles, output duty, active, done, err);
endinterface

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: prescaler pulsing tick every TICK_DIV clocks, held at zero while clr
module pwm_tick_gen #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick = cnt_q == W'(TICK_DIV - 1);
    always_comb cnt_d = (clr || tick) ? '0 : cnt_q + W'(1);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/servo_sweep_ctrl.sv
// servo_sweep_ctrl: start/stop controlled duty sweep min->max->min with dwells, for pwm_enhanced.duty
module servo_sweep_ctrl import pwm_pkg::*; #(
    parameter int R           = PWM_RES,
    parameter int TICK_DIV    = 12500000,
    parameter int DWELL_TICKS = 4
) (
    input logic clk,
    input logic rst,
    servo_sweep_ctrl_if.slave bus
);
    localparam int DW = DWELL_TICKS > 1 ? $clog2(DWELL_TICKS) : 1;
    localparam logic [R+1:0] FULL = {2'b01, {R{1'b0}}};
    sweep_state_t state_q, state_d;
    logic [R:0] duty_q, duty_d, min_q, min_d, max_q, max_d;
    logic [R-1:0] step_q, step_d;
    logic [7:0] n_q, n_d, cyc_q, cyc_d, cyc_nx;
    logic [DW-1:0] dwell_q, dwell_d;
    logic done_q, done_d, err_q, err_d;
    logic tick, idle, bad, dwell_last;
    logic [R+1:0] sum, lo_lim;
    assign idle = state_q == IDLE;
    pwm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .clr(idle), .tick(tick));
    // comparisons carried in R+2 bits so max=2**R plus step cannot wrap
    assign sum        = {1'b0, duty_q} + {2'b00, step_q};
    assign lo_lim     = {1'b0, min_q} + {2'b00, step_q};
    assign bad        = (bus.min_duty > bus.max_duty) || ({1'b0, bus.max_duty} > FULL) || (bus.step == '0);
    assign dwell_last = dwell_q == DW'(DWELL_TICKS - 1);
    assign cyc_nx     = cyc_q + 8'd1;
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        min_d   = min_q;
        max_d   = max_q;
        step_d  = step_q;
        n_d     = n_q;
        cyc_d   = cyc_q;
        dwell_d = dwell_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (idle) begin
            if (bus.start && !bus.stop) begin
                if (bad) err_d = 1'b1;
                else begin
                    min_d   = bus.min_duty;
                    max_d   = bus.max_duty;
                    step_d  = bus.step;
                    n_d     = bus.n_cycles;
                    duty_d  = bus.min_duty;
                    cyc_d   = '0;
                    dwell_d = '0;
                    state_d = RISE;
                end
            end
        end else if (bus.stop) begin
            state_d = IDLE;
            duty_d  = min_q;
        end else if (tick) begin
            case (state_q)
                RISE: begin
                    duty_d  = sum >= {1'b0, max_q} ? max_q : sum[R:0];
                    state_d = sum >= {1'b0, max_q} ? DWELL_HI : RISE;
                end
                DWELL_HI: begin
                    dwell_d = dwell_last ? '0 : dwell_q + DW'(1);
                    state_d = dwell_last ? FALL : DWELL_HI;
                end
                FALL: begin
                    duty_d  = {1'b0, duty_q} <= lo_lim ? min_q : duty_q - {1'b0, step_q};
                    state_d = {1'b0, duty_q} <= lo_lim ? DWELL_LO : FALL;
                end
                DWELL_LO: begin
                    dwell_d = dwell_last ? '0 : dwell_q + DW'(1);
                    if (dwell_last) begin
                        cyc_d   = cyc_nx;
                        done_d  = (n_q != 0) && (cyc_nx == n_q);
                        state_d = done_d ? IDLE : RISE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            min_q   <= '0;
            max_q   <= '0;
            step_q  <= '0;
            n_q     <= '0;
            cyc_q   <= '0;
            dwell_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            min_q   <= min_d;
            max_q   <= max_d;
            step_q  <= step_d;
            n_q     <= n_d;
            cyc_q   <= cyc_d;
            dwell_q <= dwell_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    assign bus.duty   = duty_q;
    assign bus.active = !idle;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_servo_sweep_ctrl.sv
// tb_servo_sweep_ctrl: directed and random sweeps checked cycle by cycle against a per-tick duty trajectory model
module tb_servo_sweep_ctrl;
    localparam int TD = 4;
    localparam int DT = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    int exp_q[$];
    servo_sweep_ctrl_if #(.R(8)) bus ();
    servo_sweep_ctrl #(.R(8), .TICK_DIV(TD), .DWELL_TICKS(DT)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic status(input string tag, input int duty, input int act, input int dn, input int er);
        chk({tag, "_duty"}, 32'(bus.duty), duty);
        chk({tag, "_active"}, 32'(bus.active), act);
        chk({tag, "_done"}, 32'(bus.done), dn);
        chk({tag, "_err"}, 32'(bus.err), er);
    endtask

    // duty after each tick of nsw full sweeps; each ramp takes ceil(span/step) ticks, at least one
    task automatic build(input int mn, input int mx, input int st, input int nsw);
        int k;
        exp_q.delete();
        k = (mx - mn + st - 1) / st;
        for (int s = 0; s < nsw; s++) begin
            if (k == 0) exp_q.push_back(mx);
            for (int i = 1; i <= k; i++) exp_q.push_back(mn + i * st > mx ? mx : mn + i * st);
            repeat (DT) exp_q.push_back(mx);
            if (k == 0) exp_q.push_back(mn);
            for (int i = 1; i <= k; i++) exp_q.push_back(mx - i * st < mn ? mn : mx - i * st);
            repeat (DT) exp_q.push_back(mn);
        end
    endtask

    task automatic drive(input int mn, input int mx, input int st, input int n, input logic s, input logic p);
        bus.min_duty = 9'(mn);
        bus.max_duty = 9'(mx);
        bus.step     = 8'(st);
        bus.n_cycles = 8'(n);
        bus.start    = s;
        bus.stop     = p;
    endtask

    task automatic start_sweep(input int mn, input int mx, input int st, input int n);
        @(negedge clk);
        drive(mn, mx, st, n, 1'b1, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        status("start", mn, 1, 0, 0);
    endtask

    task automatic reject(input int mn, input int mx, input int st, input int duty);
        @(negedge clk);
        drive(mn, mx, st, 1, 1'b1, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        status("reject", duty, 0, 0, 1);
        @(negedge clk);
        status("reject_after", duty, 0, 0, 0);
    endtask

    // lim<0 runs the whole trajectory; poke>=0 pulses a start with other limits during that tick interval
    task automatic run(input int mn, input int mx, input int st, input int nprog, input int nsw, input int lim, input int poke);
        int cur, ticks, last;
        logic tk, dn;
        build(mn, mx, st, nsw);
        last  = exp_q.size() - 1;
        ticks = lim < 0 ? exp_q.size() : lim;
        cur   = mn;
        for (int t = 0; t < ticks; t++) begin
            for (int c = 1; c <= TD; c++) begin
                if (poke == t && c == 2) drive(3, 200, 7, 1, 1'b1, 1'b0);
                if (poke == t && c == 3) bus.start = 1'b0;
                @(negedge clk);
                tk = c == TD;
                if (tk) cur = exp_q[t];
                dn = tk && t == last && nprog != 0;
                status("run", cur, dn ? 0 : 1, dn ? 1 : 0, 0);
            end
        end
        if (lim < 0 && nprog != 0) begin
            @(negedge clk);
            status("after_done", mn, 0, 0, 0);
        end
    endtask

    initial begin
        int mn, mx, st, n;
        drive(0, 0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        status("reset", 0, 0, 0, 0);
        rst = 1'b0;
        start_sweep(10, 40, 10, 1);
        run(10, 40, 10, 1, 1, -1, -1);
        reject(50, 20, 5, 10);
        reject(10, 257, 5, 10);
        reject(10, 40, 0, 10);
        start_sweep(0, 25, 10, 1);
        run(0, 25, 10, 1, 1, -1, -1);
        start_sweep(250, 256, 3, 1);
        run(250, 256, 3, 1, 1, -1, -1);
        start_sweep(77, 77, 5, 1);
        run(77, 77, 5, 1, 1, -1, -1);
        start_sweep(10, 60, 10, 1);
        run(10, 60, 10, 1, 1, 2, -1);
        chk("pre_stop_duty", 32'(bus.duty), 30);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        status("stop", 10, 0, 0, 0);
        @(negedge clk);
        drive(5, 100, 5, 1, 1'b1, 1'b1);
        @(negedge clk);
        drive(5, 100, 5, 1, 1'b0, 1'b0);
        status("start_stop_idle", 10, 0, 0, 0);
        start_sweep(20, 50, 15, 0);
        run(20, 50, 15, 0, 3, -1, 5);
        chk("free_run_active", 32'(bus.active), 1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        status("free_run_stop", 20, 0, 0, 0);
        start_sweep(10, 40, 10, 1);
        run(10, 40, 10, 1, 1, 6, -1);
        chk("pre_rst_duty", 32'(bus.duty), 30);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        status("mid_rst", 0, 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            mn = int'($urandom_range(0, 200));
            mx = int'($urandom_range(mn, 256));
            st = int'($urandom_range((mx - mn) / 6 + 1, 255));
            n  = int'($urandom_range(1, 2));
            start_sweep(mn, mx, st, n);
            run(mn, mx, st, n, n, -1, -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
